// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM state type and iteration count shared by the
// multiply/divide unit, its iterative datapath and its interface.
package muldiv_pkg;

  localparam int MD_ITERS = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } md_state_e;

  function automatic logic is_mul_op(input logic [2:0] op);
    return op[2:1] == 2'b00;
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return op[2:1] == 2'b01;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: controller-to-muldiv bus. The controller is master (drives op,
// strobe and operands); the unit is slave (drives HI/LO/busy).
interface muldiv_if #(parameter int WIDTH = 32);
  logic [2:0]       muldivOP;
  logic             muldivWE;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             busy;

  modport master (output muldivOP, muldivWE, A, B, input HI, LO, busy);
  modport slave  (input muldivOP, muldivWE, A, B, output HI, LO, busy);
endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter: one-bit-per-cycle datapath on unsigned magnitudes.
// Multiply: acc = {partial, multiplier}, shift-add right each step.
// Divide:   acc = {remainder, dividend/quotient}, restoring step, shift left.
// acc_next is the result of the step taken on the coming edge, so the
// owner can capture the final value on the same edge as the last step.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   ld_acc,    // multiplier or dividend
  input  logic [WIDTH-1:0]   ld_opnd,   // multiplicand or divisor
  input  logic               step,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               last
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [CNT_W-1:0]   cnt;
  logic               div_mode;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   diff;

  // Single shift-add or restoring-subtract step on the current accumulator.
  always_comb begin
    sum      = '0;
    rem_sh   = '0;
    diff     = '0;
    acc_next = acc;
    if (div_mode) begin
      rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      // When rem_sh >= opnd the true difference is < opnd, so W bits suffice.
      diff   = rem_sh[WIDTH-1:0] - opnd;
      if (rem_sh >= {1'b0, opnd})
        acc_next = {diff, acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // Accumulator/counter: load on start, advance one step per enabled cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      opnd     <= '0;
      cnt      <= '0;
      div_mode <= 1'b0;
    end else if (start) begin
      acc      <= {{WIDTH{1'b0}}, ld_acc};
      opnd     <= ld_opnd;
      cnt      <= '0;
      div_mode <= is_div;
    end else if (step) begin
      acc      <= acc_next;
      cnt      <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle mult/multu/div/divu with HI/LO registers and
// single-cycle mthi/mtlo. Starts are ignored while busy.
// Optional macro MULDIV_FAST_MUL_EN: mult/multu use a registered full-width
// multiply (busy for one cycle); division is always iterative.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_ITERS
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  md_state_e          state;
  logic               busy_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               neg_q;     // negate product / quotient
  logic               neg_r;     // negate remainder
  logic               div0;

  logic [2:0]         op;
  logic               signed_op, sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               start_mul, start_div;
  logic               iter_start, iter_step, last;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign op        = bus.muldivOP;
  assign signed_op = ~op[0];
  assign sa        = signed_op & bus.A[WIDTH-1];
  assign sb        = signed_op & bus.B[WIDTH-1];
  assign mag_a     = sa ? -bus.A : bus.A;
  assign mag_b     = sb ? -bus.B : bus.B;

  assign start_mul = (state == IDLE) && bus.muldivWE && is_mul_op(op);
  assign start_div = (state == IDLE) && bus.muldivWE && is_div_op(op);

  assign iter_start = start_div || (start_mul && !FAST_MUL);
  assign iter_step  = (state == DIV) || ((state == MUL) && !FAST_MUL);

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .reset    (reset),
    .start    (iter_start),
    .is_div   (start_div),
    .ld_acc   (start_div ? mag_a : mag_b),
    .ld_opnd  (start_div ? mag_b : mag_a),
    .step     (iter_step),
    .acc_next (acc_next),
    .last     (last)
  );

  // Sign fix-up on the final step's result. With a zero divisor the
  // remainder path ends holding |A|, so restoring its sign yields A itself.
  assign prod_fix = neg_q ? -acc_next : acc_next;
  assign quot_fix = div0 ? '1 : (neg_q ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0]);
  assign rem_fix  = neg_r ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  logic [2*WIDTH-1:0] fast_prod_d;
  // Sign-extended operands make one multiplier serve both signednesses.
  assign fast_prod_d = {{WIDTH{sa}}, bus.A} * {{WIDTH{sb}}, bus.B};
`endif

  // Control FSM plus HI/LO/busy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
      fast_prod <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_mul) begin
            state  <= MUL;
            busy_q <= 1'b1;
            neg_q  <= sa ^ sb;
`ifdef MULDIV_FAST_MUL_EN
            fast_prod <= fast_prod_d;
`endif
          end else if (start_div) begin
            state  <= DIV;
            busy_q <= 1'b1;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            div0   <= (bus.B == '0);
          end else if (bus.muldivWE && op == MD_MTHI) begin
            hi_q <= bus.A;
          end else if (bus.muldivWE && op == MD_MTLO) begin
            lo_q <= bus.A;
          end
        end
        MUL: begin
`ifdef MULDIV_FAST_MUL_EN
          {hi_q, lo_q} <= fast_prod;
          state        <= IDLE;
          busy_q       <= 1'b0;
`else
          if (last) begin
            {hi_q, lo_q} <= prod_fix;
            state        <= IDLE;
            busy_q       <= 1'b0;
          end
`endif
        end
        DIV: begin
          if (last) begin
            lo_q   <= quot_fix;
            hi_q   <= rem_fix;
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifndef MULDIV_FAST_MUL_EN
  // Product fix-up is only consumed by the iterative multiply path.
`endif

  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench. Each op pushes its expected {HI,LO}
// (from a behavioural model using native arithmetic) and pops it when busy
// drops; busy duration and HI/LO hold during an operation are also checked.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 32;
`endif
  localparam int DIV_LAT = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int errs = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [31:0] hi_m = '0, lo_m = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    case (op)
      3'b000: begin p = longint'($signed(a)) * longint'($signed(b)); return p; end
      3'b001: return {32'b0, a} * {32'b0, b};
      3'b010: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        sa = longint'($signed(a)); sb = longint'($signed(b));
        q = sa / sb; r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'b011: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'b100: return {a, lo_m};
      3'b101: return {hi_m, a};
      default: return {hi_m, lo_m};
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op);
    if (op[2:1] == 2'b00) return MUL_LAT;
    if (op[2:1] == 2'b01) return DIV_LAT;
    return 0;
  endfunction

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [63:0] e;
    @(negedge clk);
    bus.muldivOP = op; bus.A = a; bus.B = b; bus.muldivWE = 1'b1;
    exp_q.push_back(model(op, a, b));
    @(negedge clk);
    bus.muldivWE = 1'b0;
    if (bus.busy && lat_of(op) > 1) chk({tag, " hold"}, {bus.HI, bus.LO}, {hi_m, lo_m});
    n = 0;
    while (bus.busy && n < 100) begin n++; @(negedge clk); end
    chk({tag, " busy"}, 64'(n), 64'(lat_of(op)));
    e = exp_q.pop_front();
    chk(tag, {bus.HI, bus.LO}, e);
    {hi_m, lo_m} = e;
  endtask

  initial begin
    int n;
    logic [63:0] e;
    logic [2:0] rop;
    logic [31:0] ra, rb;

    reset = 1'b1;
    bus.muldivOP = '0; bus.A = '0; bus.B = '0; bus.muldivWE = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset hilo", {bus.HI, bus.LO}, 64'h0);
    chk("reset busy", 64'(bus.busy), 64'h0);
    reset = 1'b0;

    do_op("mult",     MD_MULT,  32'hFFFF_FFFD, 32'd7);
    do_op("multu",    MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("div",      MD_DIV,   32'hFFFF_FFF9, 32'd2);
    do_op("divu",     MD_DIVU,  32'd100,       32'd7);
    do_op("div0",     MD_DIV,   32'd5,         32'd0);
    do_op("div0neg",  MD_DIV,   32'hFFFF_FF00, 32'd0);
    do_op("divu0",    MD_DIVU,  32'h8000_0001, 32'd0);
    do_op("divovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    do_op("multmix",  MD_MULT,  32'h7FFF_FFFF, 32'h8000_0000);
    do_op("mthi",     MD_MTHI,  32'h0000_1234, 32'd0);
    do_op("mtlo",     MD_MTLO,  32'h0000_5678, 32'd0);
    do_op("nop110",   3'b110,   32'hDEAD_BEEF, 32'd3);
    do_op("nop111",   3'b111,   32'hDEAD_BEEF, 32'd3);

    // Starts while busy must be ignored: no restart, no HI write.
    @(negedge clk);
    bus.muldivOP = MD_DIVU; bus.A = 32'd1000; bus.B = 32'd9; bus.muldivWE = 1'b1;
    exp_q.push_back(model(MD_DIVU, 32'd1000, 32'd9));
    @(negedge clk);
    bus.muldivWE = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      if (n == 4) begin
        bus.muldivOP = MD_MTHI; bus.A = 32'hDEAD; bus.muldivWE = 1'b1;
      end else if (n == 5) begin
        bus.muldivOP = MD_MULT; bus.A = 32'd3; bus.B = 32'd3; bus.muldivWE = 1'b1;
      end else begin
        bus.muldivWE = 1'b0;
      end
      @(negedge clk);
    end
    bus.muldivWE = 1'b0;
    chk("ignore busy", 64'(n), 64'(DIV_LAT));
    e = exp_q.pop_front();
    chk("ignore", {bus.HI, bus.LO}, e);
    {hi_m, lo_m} = e;

    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      do_op("rand", rop, ra, rb);
    end

    // Reset mid-operation discards the result and clears HI/LO.
    do_op("premul", MD_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge clk);
    bus.muldivOP = MD_DIV; bus.A = 32'd77; bus.B = 32'd5; bus.muldivWE = 1'b1;
    @(negedge clk);
    bus.muldivWE = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst busy", 64'(bus.busy), 64'h0);
    chk("midrst hilo", {bus.HI, bus.LO}, 64'h0);
    reset = 1'b0;
    hi_m = '0; lo_m = '0;
    do_op("postrst", MD_MULT, 32'hFFFF_FFFD, 32'd7);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit with HI/LO registers. It is the responder on the `muldivOP`/`muldivWE` interface driven by the multicycle controller. It executes mult, multu, div, divu iteratively over 32 cycles, and mthi/mtlo in one cycle. It reports progress on `busy` and exposes HI/LO to the writeback mux for mfhi/mflo.

## Interface
- `WIDTH`, 32: operand and HI/LO width; the iteration count equals `WIDTH`.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `muldivOP` in 3: operation. 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110 and 111 are no-op.
- `muldivWE` in 1: start/write strobe, sampled on the rising edge.
- `A` in WIDTH: GPR[rs]; dividend or multiplicand; data source for mthi/mtlo.
- `B` in WIDTH: GPR[rt]; divisor or multiplier.
- `HI` out WIDTH: HI register.
- `LO` out WIDTH: LO register.
- `busy` out 1: high while an iterative operation is in flight.

## Operation
- **States:**
  - IDLE → MUL when `muldivWE` and op ∈ {000, 001}.
  - IDLE → DIV when `muldivWE` and op ∈ {010, 011}.
  - MUL or DIV → IDLE when the count reaches `WIDTH`.
- **Start (IDLE):**
  - Latch `A`, `B` and the signed flag (`op[0]==0`).
  - Signed ops take operand magnitudes and record the result signs:
    - product and quotient sign = sA^sB
    - remainder sign = sA
  - Clear the accumulator and the 6-bit iteration counter.
- **MUL:** shift-add over one multiplier bit per cycle; 64-bit accumulator.
- **DIV:** restoring division producing one quotient bit per cycle.
- **Completion (last iteration):**
  - Apply the sign fix-up (two's-complement negate where the sign is set).
  - mult/multu: {HI,LO} ← 64-bit product.
  - div/divu: LO ← quotient, HI ← remainder.
- **mthi/mtlo in IDLE:**
  - HI ← A (mthi) or LO ← A (mtlo) on the same edge.
  - `busy` stays 0.
- **`muldivWE` while `busy`:** ignored completely; no restart and no HI/LO write. The controller must stall mfhi/mflo/mult/div while `busy` is high.
- **Op 110/111:** no effect.
- **Divide by zero (any signedness):** HI ← A, LO ← 32'hFFFFFFFF. No sign fix-up, no trap.
- **Signed 0x80000000 / −1:** LO = 0x80000000, HI = 0.
- **Reset (any state, including mid-operation):**
  - State ← IDLE, `busy` = 0, HI = LO = 0, counter = 0.
  - The in-flight result is discarded.

## Timing
- Start accepted at edge E0.
- `busy` is 1 from after E0 through E32. HI/LO are written at E32, and `busy` falls at E32.
  - Latency: 32 cycles.
- A new start can be accepted at E32+1 at the earliest.
- HI/LO hold their old values during the operation.
- mthi/mtlo: single-cycle latency. The value is visible after the accepting edge.
- HI/LO and `busy` are registered outputs; there is no combinational path from inputs to outputs.

## Configuration
- `MULDIV_FAST_MUL_EN`:
  - **Defined:** mult/multu use a registered combinational multiply.
    - `busy` is high for exactly one cycle.
    - {HI,LO} are written at E1.
  - **Undefined:** the 32-cycle shift-add path described above.
- Division is always iterative, regardless of the macro.

## Structure
- **`muldiv_pkg`** holds:
  - the op encodings (`MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO`)
  - the state enum (IDLE, MUL, DIV)
  - the iteration-count constant
- **One sub-module, `muldiv_iter`:**
  - Per-cycle datapath: shift-add step and restoring subtract step.
  - Contains the accumulator and counter.
- **Top level** (FSM, sign handling, HI/LO registers) instantiates `muldiv_iter`.

## Test plan
- **mult signed:** A=−3 (0xFFFFFFFD), B=7, WE pulse → `busy` for 32 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- **multu:** A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 after 32 cycles.
- **div signed:** A=−7, B=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- **divu:** A=100, B=7 → LO=14, HI=2.
- **Divide by zero:** div A=5, B=0 → HI=5, LO=0xFFFFFFFF.
- **mthi/mtlo and mid-operation events:**
  - mthi A=0x1234 then mtlo A=0x5678 → HI=0x1234, LO=0x5678, `busy` never rises.
  - A start during `busy` is ignored: the result matches the first op.
  - `reset` at iteration 10 → `busy`=0 and HI=LO=0 on the next cycle.
